// File: rtl/rom_read_arbiter_if.sv
// Requester-side bus of rom_read_arbiter.
//   req_valid  : per-requester read pending
//   req_addr   : packed per-requester addresses, slice i = [i*ROM_ADDR_BITS +: ROM_ADDR_BITS]
//   req_ready  : one-hot (or zero) accept strobe
//   rsp_valid  : one-hot (or zero) response strobe
//   rsp_data   : returned ROM word, shared by all requesters
// master = requester side, slave = arbiter side.
interface rom_read_arbiter_if #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ROM_ADDR_BITS = 14,
  parameter int unsigned ROM_WIDTH     = 1
);
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*ROM_ADDR_BITS-1:0] req_addr;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [ROM_WIDTH-1:0]             rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port ROM (1-cycle registered read)
// between NUM_REQ requesters. At most one read accepted per cycle; the word returns two
// cycles after acceptance with a one-hot rsp_valid pulse naming its requester.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : requester handshake and response bus
//   rom_address  : ROM address (0 when idle)
//   rom_enable   : ROM read enable, high exactly when a request is accepted
//   rom_data     : ROM output register
module rom_read_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ROM_ADDR_BITS = 14,
  parameter int unsigned ROM_WIDTH     = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rom_read_arbiter_if.slave        bus,
  output logic [ROM_ADDR_BITS-1:0] rom_address,
  output logic                     rom_enable,
  input  logic [ROM_WIDTH-1:0]     rom_data
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]      win, cand;
  logic [31:0]          idx;
  logic                 found;
  logic [NUM_REQ-1:0]   grant;

  logic                 s1_valid_q;
  logic [PtrW-1:0]      s1_id_q;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [ROM_WIDTH-1:0] rsp_data_q;

  // Search valid bits from rr_ptr upward with wrap; first hit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx  = (32'(rr_ptr_q) + k) % NUM_REQ;
      cand = PtrW'(idx);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    // No accepts while reset is held, even if requesters are valid.
    if (!rst_n) begin
      found = 1'b0;
    end
  end

  always_comb begin
    grant       = found ? (NUM_REQ'(1) << win) : '0;
    rom_address = found ? bus.req_addr[win*ROM_ADDR_BITS +: ROM_ADDR_BITS] : '0;
    rr_ptr_d    = rr_ptr_q;
    if (found) begin
      rr_ptr_d = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    end
    rsp_valid_d = s1_valid_q ? (NUM_REQ'(1) << s1_id_q) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= found;
      s1_id_q     <= win;
      rsp_valid_q <= rsp_valid_d;
      // rom_data is only meaningful in the cycle after an accept.
      if (s1_valid_q) begin
        rsp_data_q <= rom_data;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign rom_enable    = found;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed steps then random traffic, checked against a
// round-robin / response-queue reference model.
module tb_rom_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 1;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rom_address;
  logic          rom_enable;
  logic [DW-1:0] rom_data;

  rom_read_arbiter_if #(.NUM_REQ(N), .ROM_ADDR_BITS(AW), .ROM_WIDTH(DW)) bus ();

  rom_read_arbiter #(.NUM_REQ(N), .ROM_ADDR_BITS(AW), .ROM_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .rom_address (rom_address),
    .rom_enable  (rom_enable),
    .rom_data    (rom_data)
  );

  // ROM: enable-gated output register, not reset.
  logic [DW-1:0] rom_mem [0:(1<<AW)-1];
  always @(posedge clk) if (rom_enable) rom_data <= rom_mem[rom_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          q[$];
  bit            pend [N];
  logic [AW-1:0] raddr [N];
  int            ptr;
  logic [DW-1:0] last;
  int            cyc;
  int            last_w;
  int            checks;
  int            failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_rst(input logic v);
    rst_n = v;
    if (!v) begin
      q.delete();
      ptr  = 0;
      last = '0;
    end
  endtask

  // One clock cycle: drive requesters, check at negedge, advance model at posedge.
  task automatic tick();
    logic [N-1:0]    v;
    logic [N*AW-1:0] a;
    logic [N-1:0]    er, ev;
    logic [AW-1:0]   ea;
    logic [DW-1:0]   ed;
    int              w;
    for (int i = 0; i < N; i++) begin
      v[i]            = pend[i];
      a[i*AW +: AW]   = raddr[i];
    end
    bus.req_valid = v;
    bus.req_addr  = a;
    @(negedge clk);
    w = -1;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
      end
    end
    er = (w >= 0) ? (N'(1) << w) : '0;
    ea = (w >= 0) ? raddr[w] : '0;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("rom_enable", 32'(rom_enable), 32'(w >= 0));
    chk("rom_address", 32'(rom_address), 32'(ea));
    ev = '0;
    ed = last;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev   = N'(1) << q[0].id;
      ed   = q[0].data;
      last = ed;
      void'(q.pop_front());
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
    chk("rsp_data", 32'(bus.rsp_data), 32'(ed));
    chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
    chk("rsp_onehot", 32'($countones(bus.rsp_valid) <= 1), 32'd1);
    chk("enable_eq_ready", 32'(rom_enable), 32'(|bus.req_ready));
    @(posedge clk);
    last_w = w;
    if (w >= 0) begin
      q.push_back('{due: cyc + 2, id: w, data: rom_mem[raddr[w]]});
      ptr     = (w + 1) % N;
      pend[w] = 1'b0;
    end
    cyc++;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    ptr      = 0;
    last     = '0;
    last_w   = -1;
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = DW'(i % 2);
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b1;
      raddr[i] = AW'($urandom);
    end
    set_rst(1'b0);

    // Held in reset with all requesters valid: nothing accepted.
    repeat (2) tick();

    // Round-robin saturation from reset release.
    set_rst(1'b1);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) raddr[i] = AW'($urandom);
        pend[i] = 1'b1;
      end
      tick();
      chk("sat_grant", 32'(last_w), 32'(k % N));
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (3) tick();

    // Single read: requester 2, address 5.
    pend[2] = 1'b1; raddr[2] = AW'(5);
    tick();
    chk("single_grant", 32'(last_w), 32'd2);
    repeat (5) tick();

    // Pointer skip: grant 0 alone, then 0 and 3 valid -> 3 then 0.
    pend[0] = 1'b1; raddr[0] = AW'(100);
    tick();
    pend[0] = 1'b1; raddr[0] = AW'(7);
    pend[3] = 1'b1; raddr[3] = AW'(8);
    tick();
    chk("skip_first", 32'(last_w), 32'd3);
    tick();
    chk("skip_second", 32'(last_w), 32'd0);
    repeat (2) tick();

    // Back-to-back same requester.
    for (int k = 0; k < 3; k++) begin
      pend[1] = 1'b1; raddr[1] = AW'(10 + k);
      tick();
    end
    // Drain, then idle hold.
    repeat (7) tick();

    // Reset mid-flight: requester 3 accepted, then reset before its response.
    pend[3] = 1'b1; raddr[3] = AW'(9);
    tick();
    set_rst(1'b0);
    repeat (2) tick();
    set_rst(1'b1);
    pend[0] = 1'b1; raddr[0] = AW'(21);
    pend[3] = 1'b1; raddr[3] = AW'(22);
    tick();
    chk("post_reset_first", 32'(last_w), 32'd0);
    repeat (4) tick();

    // Random traffic with one reset pulse in the middle.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i]  = 1'b1;
          raddr[i] = AW'($urandom);
        end
      end
      if (k == 200) set_rst(1'b0);
      if (k == 202) set_rst(1'b1);
      tick();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
